alu_md_sequencer: RTL and testbench
===================================

# alu_md_sequencer

Parametrised successor to the ALU operation decoder. It decodes opcode/func into the 4-bit ALU operation code and adds an iterative signed multiply/divide engine with HI/LO result registers and a ready/valid handshake. It sits between the decode stage and the execute datapath. The decoded operation is registered, and the pipeline is stalled while a MULT or DIV is iterating.

## Interface
**Parameters**
- `WIDTH`, 32: operand width and HI/LO width; any value ≥ 4.

**Ports**
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `valid_in`  in  1: an instruction is presented.
- `opcode`  in  6: instruction opcode.
- `func`  in  6: R-type function field.
- `rs_val`  in  WIDTH: dividend or multiplicand.
- `rt_val`  in  WIDTH: divisor or multiplier.
- `ready`  out  1: the block accepts an instruction this cycle.
- `alu_operation`  out  4: registered decoded operation.
- `op_valid`  out  1: one-cycle pulse; `alu_operation` is valid.
- `illegal`  out  1: qualifies `op_valid`; the instruction did not decode.
- `md_done`  out  1: one-cycle pulse; HI/LO were just written.
- `div_by_zero`  out  1: qualifies `md_done`.
- `hi`  out  WIDTH: HI register.
- `lo`  out  WIDTH: LO register.

## Operation
- **Encoding:** NOP=0, XOR=1, OR=2, AND=3, NOR=4, SLL=5, SRL=6, SLT=7, ADD=8, ADDU=9, SUB=10, SUBU=11, MULT=12, DIV=13.
- **R-type decode** (opcode 000000), by func:
  - 000100 → SLL; 000110 → SRL; 100110 → XOR; 100010 → SUB; 101010 → SLT; 100011 → SUBU.
  - 100101 → OR; 100111 → NOR; 100001 → ADDU; 100000 → ADD; 100100 → AND.
  - 011000 → MULT; 011010 → DIV.
- **I-type decode**, by opcode:
  - 001110 → XOR; 001010 → SLT; 001000 → ADD; 001100 → AND; 001101 → OR; 001001 → ADDU.
  - 000100 and 000101 → SUB.
  - 000110, 000111, 000001 → NOP, not illegal.
- **Undecoded input:** any other combination gives NOP with `illegal`=1. Decode is fully specified and infers no latches.
- **Accept:** an instruction is accepted when `valid_in` && `ready`. Operands are captured on the accepting edge.
- **States:** IDLE, BUSY, DONE. `ready` = (state==IDLE).
  - IDLE → BUSY: accepted MULT, or accepted DIV with `rt_val`≠0.
  - IDLE → DONE: accepted DIV with `rt_val`==0.
  - BUSY → DONE: iteration counter reaches WIDTH. The counter is $clog2(WIDTH)+1 bits and is cleared on entry.
  - DONE → IDLE: unconditionally.
- **Multiply:** signed. Operate on the magnitudes |rs|, |rt|. Shift-add one multiplier bit per cycle into a 2·WIDTH accumulator. If the operand signs differ, two's-complement negate the 2·WIDTH product. HI gets the upper WIDTH bits, LO the lower WIDTH bits.
- **Divide:** signed, restoring, one quotient bit per cycle on the magnitudes.
  - Quotient is negated if the signs differ. Remainder takes the sign of the dividend.
  - LO gets the quotient, HI the remainder.
  - Most-negative ÷ −1 gives LO = most-negative and HI = 0 (wraps, no flag).
- **Divide by zero:** LO = all ones, HI = `rs_val`, `div_by_zero`=1.
- **Register updates:** HI/LO change only on entry to DONE; otherwise they hold.
- **Ignored input:** `valid_in` while `ready`=0 is ignored (dropped, not queued).

## Timing
- **Reset:** asynchronous, from any state.
  - State = IDLE, `ready`=1.
  - `alu_operation`=0, `op_valid`=0, `illegal`=0, `md_done`=0, `div_by_zero`=0, `hi`=0, `lo`=0.
  - An in-flight MULT/DIV is aborted and produces no `md_done`.
- **Non-MULT/DIV instruction accepted at edge N:**
  - `alu_operation`, `op_valid`=1 and `illegal` are visible in cycle N+1.
  - `ready` stays 1, so back-to-back accepts give `op_valid` on consecutive cycles.
- **MULT/DIV accepted at edge N:**
  - BUSY in cycles N+1 … N+WIDTH.
  - DONE in cycle N+WIDTH+1, with `md_done`=1, `op_valid`=1, `alu_operation`=12 or 13, and new `hi`/`lo` visible.
  - IDLE again at N+WIDTH+2. This is the earliest next accept edge.
- **DIV by zero accepted at edge N:** DONE in cycle N+1; IDLE at N+2.
- **Pulse widths:** `op_valid`, `md_done`, `illegal` and `div_by_zero` are exactly one cycle wide.
- **Between pulses:** `alu_operation` holds its last value.

## Test plan
- **Simple decode:** reset, then accept opcode 000000/func 100000 → next cycle `alu_operation`=8, `op_valid`=1, `illegal`=0, `ready`=1.
- **Illegal and branch decode:** accept opcode 000000/func 111111 → `alu_operation`=0, `illegal`=1. Then accept opcode 000111 → NOP, `illegal`=0.
- **MULT (WIDTH=32):** rs=0xFFFFFFFD, rt=7 → `ready`=0 for 33 cycles. `md_done` at N+33 with hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- **DIV with mixed signs:** 7 ÷ −2 → lo=0xFFFFFFFD, hi=1. −7 ÷ 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also 0x80000000 ÷ 0xFFFFFFFF → lo=0x80000000, hi=0.
- **DIV by zero:** rs=5, rt=0 → `md_done` and `div_by_zero` at N+1, lo=0xFFFFFFFF, hi=5, `ready` again at N+2.
- **Reset and stall:** assert `rst_n`=0 in BUSY cycle 10 of a MULT → immediately `ready`=1 and hi=lo=0, with no `md_done` afterwards. Separately, `valid_in` pulses during BUSY produce no `op_valid`.

Source files
------------

// File: rtl/alu_md_sequencer_if.sv
// Decode-stage to execute-stage bus for alu_md_sequencer: instruction
// presentation with ready/valid, decoded operation and HI/LO results.
interface alu_md_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             valid_in;
    logic [5:0]       opcode;
    logic [5:0]       func;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             ready;
    logic [3:0]       alu_operation;
    logic             op_valid;
    logic             illegal;
    logic             md_done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output valid_in, opcode, func, rs_val, rt_val,
        input  ready, alu_operation, op_valid, illegal, md_done, div_by_zero, hi, lo
    );

    modport slave (
        input  valid_in, opcode, func, rs_val, rt_val,
        output ready, alu_operation, op_valid, illegal, md_done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/alu_md_sequencer.sv
// ALU operation decoder with an iterative signed multiply/divide engine.
// One multiplier/quotient bit per cycle; HI/LO update only on entry to DONE.
module alu_md_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_md_sequencer_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,  OP_XOR  = 4'd1,  OP_OR   = 4'd2,  OP_AND  = 4'd3,
        OP_NOR  = 4'd4,  OP_SLL  = 4'd5,  OP_SRL  = 4'd6,  OP_SLT  = 4'd7,
        OP_ADD  = 4'd8,  OP_ADDU = 4'd9,  OP_SUB  = 4'd10, OP_SUBU = 4'd11,
        OP_MULT = 4'd12, OP_DIV  = 4'd13
    } alu_op_e;

    state_e             state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_res;     // operand signs differ
    logic               neg_rem;     // dividend was negative
    logic [WIDTH-1:0]   mag_op;      // |multiplicand| or |divisor|
    logic [2*WIDTH-1:0] acc;         // mult: {partial, multiplier}; div: {rem, quotient}

    alu_op_e          dec_op;
    logic             dec_illegal;

    always_comb begin
        // NOTE: defaults first so every path through the case assigns both outputs; no latch.
        dec_op      = OP_NOP;
        dec_illegal = 1'b0;
        if (bus.opcode == 6'b000000) begin
            case (bus.func)
                6'b000100: dec_op = OP_SLL;
                6'b000110: dec_op = OP_SRL;
                6'b100110: dec_op = OP_XOR;
                6'b100010: dec_op = OP_SUB;
                6'b101010: dec_op = OP_SLT;
                6'b100011: dec_op = OP_SUBU;
                6'b100101: dec_op = OP_OR;
                6'b100111: dec_op = OP_NOR;
                6'b100001: dec_op = OP_ADDU;
                6'b100000: dec_op = OP_ADD;
                6'b100100: dec_op = OP_AND;
                6'b011000: dec_op = OP_MULT;
                6'b011010: dec_op = OP_DIV;
                default:   dec_illegal = 1'b1;
            endcase
        end else begin
            case (bus.opcode)
                6'b001110:                     dec_op = OP_XOR;
                6'b001010:                     dec_op = OP_SLT;
                6'b001000:                     dec_op = OP_ADD;
                6'b001100:                     dec_op = OP_AND;
                6'b001101:                     dec_op = OP_OR;
                6'b001001:                     dec_op = OP_ADDU;
                6'b000100, 6'b000101:          dec_op = OP_SUB;
                6'b000110, 6'b000111, 6'b000001: dec_op = OP_NOP;
                default:                       dec_illegal = 1'b1;
            endcase
        end
    end

    logic             rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag;

    assign rs_neg = bus.rs_val[WIDTH-1];
    assign rt_neg = bus.rt_val[WIDTH-1];
    assign rs_mag = rs_neg ? -bus.rs_val : bus.rs_val;
    assign rt_mag = rt_neg ? -bus.rt_val : bus.rt_val;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] fin_prod;
    logic [WIDTH-1:0]   fin_hi, fin_lo;
    logic [CW-1:0]      cnt_next;

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + (acc[0] ? {1'b0, mag_op} : {(WIDTH+1){1'b0}});
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_trial = div_shift - {1'b0, mag_op};
        if (is_div) begin
            // Restore on borrow: keep the shifted remainder and shift in a 0 quotient bit.
            step_acc = div_trial[WIDTH]
                     ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                     : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            step_acc = {mul_sum, acc[WIDTH-1:1]};
        end

        fin_prod = neg_res ? -step_acc : step_acc;
        if (is_div) begin
            fin_lo = neg_res ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
            fin_hi = neg_rem ? -step_acc[2*WIDTH-1:WIDTH] : step_acc[2*WIDTH-1:WIDTH];
        end else begin
            fin_lo = fin_prod[WIDTH-1:0];
            fin_hi = fin_prod[2*WIDTH-1:WIDTH];
        end
        cnt_next = cnt + CW'(1);
    end

    assign bus.ready = (state == IDLE);

    // NOTE: all state and outputs use <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            cnt               <= '0;
            is_div            <= 1'b0;
            neg_res           <= 1'b0;
            neg_rem           <= 1'b0;
            mag_op            <= '0;
            acc               <= '0;
            bus.alu_operation <= OP_NOP;
            bus.op_valid      <= 1'b0;
            bus.illegal       <= 1'b0;
            bus.md_done       <= 1'b0;
            bus.div_by_zero   <= 1'b0;
            bus.hi            <= '0;
            bus.lo            <= '0;
        end else begin
            bus.op_valid    <= 1'b0;
            bus.illegal     <= 1'b0;
            bus.md_done     <= 1'b0;
            bus.div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.valid_in) begin
                        if (dec_op == OP_MULT || dec_op == OP_DIV) begin
                            is_div  <= (dec_op == OP_DIV);
                            neg_res <= rs_neg ^ rt_neg;
                            neg_rem <= rs_neg;
                            cnt     <= '0;
                            if (dec_op == OP_DIV && bus.rt_val == '0) begin
                                state             <= DONE;
                                bus.md_done       <= 1'b1;
                                bus.div_by_zero   <= 1'b1;
                                bus.op_valid      <= 1'b1;
                                bus.alu_operation <= OP_DIV;
                                bus.lo            <= '1;
                                bus.hi            <= bus.rs_val;
                            end else if (dec_op == OP_DIV) begin
                                state  <= BUSY;
                                mag_op <= rt_mag;
                                acc    <= {{WIDTH{1'b0}}, rs_mag};
                            end else begin
                                state  <= BUSY;
                                mag_op <= rs_mag;
                                acc    <= {{WIDTH{1'b0}}, rt_mag};
                            end
                        end else begin
                            bus.alu_operation <= dec_op;
                            bus.op_valid      <= 1'b1;
                            bus.illegal       <= dec_illegal;
                        end
                    end
                end
                BUSY: begin
                    acc <= step_acc;
                    cnt <= cnt_next;
                    if (cnt_next == CW'(WIDTH)) begin
                        state             <= DONE;
                        bus.md_done       <= 1'b1;
                        bus.op_valid      <= 1'b1;
                        bus.alu_operation <= is_div ? OP_DIV : OP_MULT;
                        bus.hi            <= fin_hi;
                        bus.lo            <= fin_lo;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_md_sequencer.sv
// Randomized self-checking bench for alu_md_sequencer against a
// plain-arithmetic reference (signed longint multiply/divide, decode table).
module tb_alu_md_sequencer;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_md_sequencer_if #(.WIDTH(W)) bus ();
    alu_md_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [3:0]   m_op = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void ref_decode(input logic [5:0] opc, input logic [5:0] fn,
                                       output logic [3:0] op, output logic ill);
        op  = 4'd0;
        ill = 1'b0;
        if (opc == 6'b000000) begin
            case (fn)
                6'b000100: op = 4'd5;   6'b000110: op = 4'd6;
                6'b100110: op = 4'd1;   6'b100010: op = 4'd10;
                6'b101010: op = 4'd7;   6'b100011: op = 4'd11;
                6'b100101: op = 4'd2;   6'b100111: op = 4'd4;
                6'b100001: op = 4'd9;   6'b100000: op = 4'd8;
                6'b100100: op = 4'd3;   6'b011000: op = 4'd12;
                6'b011010: op = 4'd13;
                default:   ill = 1'b1;
            endcase
        end else begin
            case (opc)
                6'b001110: op = 4'd1;   6'b001010: op = 4'd7;
                6'b001000: op = 4'd8;   6'b001100: op = 4'd3;
                6'b001101: op = 4'd2;   6'b001001: op = 4'd9;
                6'b000100, 6'b000101: op = 4'd10;
                6'b000110, 6'b000111, 6'b000001: op = 4'd0;
                default:   ill = 1'b1;
            endcase
        end
    endfunction

    function automatic void ref_md(input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] rhi, output logic [W-1:0] rlo,
                                   output logic dbz);
        longint sa, sb, p, q, r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        dbz = 1'b0;
        if (!is_div) begin
            p   = sa * sb;
            rhi = p[63:32];
            rlo = p[31:0];
        end else if (b == '0) begin
            dbz = 1'b1;
            rlo = '1;
            rhi = a;
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            rlo = q[31:0];
            rhi = r[31:0];
        end
    endfunction

    // Called on a falling edge with the DUT idle; returns on a falling edge with the DUT idle.
    task automatic do_op(input logic [5:0] opc, input logic [5:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [3:0]   eop;
        logic         eill, edbz;
        logic [W-1:0] ehi, elo;
        int           lat;
        ref_decode(opc, fn, eop, eill);
        check({tag, "_ready"}, bus.ready, 1);
        bus.valid_in = 1'b1;
        bus.opcode   = opc;
        bus.func     = fn;
        bus.rs_val   = a;
        bus.rt_val   = b;
        if (eop == 4'd12 || eop == 4'd13) begin
            ref_md(eop == 4'd13, a, b, ehi, elo, edbz);
            lat = edbz ? 1 : W + 1;
            for (int k = 1; k <= lat; k++) begin
                @(negedge clk);
                if (k < lat) begin
                    check({tag, "_busy"}, {bus.ready, bus.op_valid, bus.md_done, bus.alu_operation},
                          {3'b000, m_op});
                    check({tag, "_hold"}, {bus.hi, bus.lo}, {m_hi, m_lo});
                    // Legal ADDs thrown at a busy block must be dropped.
                    bus.valid_in = 1'($urandom_range(0, 1));
                    bus.opcode   = 6'b000000;
                    bus.func     = 6'b100000;
                end else begin
                    bus.valid_in = 1'b0;
                    check({tag, "_done_flags"},
                          {bus.md_done, bus.op_valid, bus.illegal, bus.div_by_zero, bus.ready},
                          {1'b1, 1'b1, 1'b0, edbz, 1'b0});
                    check({tag, "_done_op"}, bus.alu_operation, eop);
                    check({tag, "_hi"}, bus.hi, ehi);
                    check({tag, "_lo"}, bus.lo, elo);
                    m_hi = ehi;
                    m_lo = elo;
                    m_op = eop;
                end
            end
            @(negedge clk);
            check({tag, "_idle"}, {bus.ready, bus.md_done, bus.op_valid, bus.div_by_zero}, 4'b1000);
        end else begin
            @(negedge clk);
            bus.valid_in = 1'b0;
            check({tag, "_flags"}, {bus.op_valid, bus.illegal, bus.ready, bus.md_done},
                  {1'b1, eill, 1'b1, 1'b0});
            check({tag, "_op"}, bus.alu_operation, eop);
            check({tag, "_hilo_hold"}, {bus.hi, bus.lo}, {m_hi, m_lo});
            m_op = eop;
        end
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic seen_done;
        logic [5:0] ropc, rfn;
        bus.valid_in = 1'b0;
        bus.opcode   = '0;
        bus.func     = '0;
        bus.rs_val   = '0;
        bus.rt_val   = '0;

        #2;
        check("reset_outputs",
              {bus.ready, bus.op_valid, bus.illegal, bus.md_done, bus.div_by_zero, bus.alu_operation},
              {1'b1, 4'b0000, 4'd0});
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op(6'b000000, 6'b100000, 32'd3, 32'd4, "add");
        do_op(6'b000000, 6'b111111, 32'd0, 32'd0, "illegal");
        @(negedge clk);
        check("pulse_width", {bus.op_valid, bus.illegal, bus.alu_operation}, {2'b00, 4'd0});
        do_op(6'b000111, 6'b000000, 32'd0, 32'd0, "branch_nop");
        do_op(6'b001101, 6'b000000, 32'd0, 32'd0, "ori_b2b");

        do_op(6'b000000, 6'b011000, 32'hFFFF_FFFD, 32'd7, "mult");
        check("mult_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        do_op(6'b000000, 6'b011010, 32'd7, 32'hFFFF_FFFE, "div_pos_neg");
        check("div_pos_neg_const", {bus.hi, bus.lo}, {32'd1, 32'hFFFF_FFFD});
        do_op(6'b000000, 6'b011010, 32'hFFFF_FFF9, 32'd2, "div_neg_pos");
        check("div_neg_pos_const", {bus.hi, bus.lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_op(6'b000000, 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, "div_wrap");
        check("div_wrap_const", {bus.hi, bus.lo}, {32'd0, 32'h8000_0000});
        do_op(6'b000000, 6'b011010, 32'd5, 32'd0, "div_zero");
        check("div_zero_const", {bus.hi, bus.lo}, {32'd5, 32'hFFFF_FFFF});

        // Reset during BUSY cycle 10 of a MULT aborts it.
        bus.valid_in = 1'b1;
        bus.opcode   = 6'b000000;
        bus.func     = 6'b011000;
        bus.rs_val   = 32'h1234_5678;
        bus.rt_val   = 32'h0000_0ABC;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus.valid_in = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("rst_busy_ready", {bus.ready, bus.md_done, bus.op_valid}, 3'b100);
        check("rst_busy_hilo", {bus.hi, bus.lo}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        m_op = '0;
        @(negedge clk);
        rst_n     = 1'b1;
        seen_done = 1'b0;
        repeat (W + 4) begin
            @(negedge clk);
            seen_done = seen_done | bus.md_done | bus.op_valid;
        end
        check("rst_no_done", seen_done, 1'b0);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: begin ropc = 6'b000000; rfn = 6'b011000; end
                3, 4, 5: begin ropc = 6'b000000; rfn = 6'b011010; end
                default: begin
                    ropc = $urandom_range(0, 1) ? 6'b000000 : 6'($urandom);
                    rfn  = 6'($urandom);
                end
            endcase
            do_op(ropc, rfn, rand_operand(), rand_operand(), $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
